// File: rtl/stage_f.sv
// stage_f: in-order fetch stage; tracks outstanding imem requests, buffers PC/instruction pairs
// in a DEPTH-entry FIFO and hands them to decode, dropping stale responses after a redirect.
module stage_f #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        ValidF,
  output logic [31:0] RDD,
  output logic        ValidD
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [31:0]   pc_q  [DEPTH];
  logic [31:0]   ins_q [DEPTH];
  logic [AW-1:0] head, tail, fill_idx;
  logic [CW-1:0] count, pend, disc;
  logic [CW:0]   outstanding;
  logic [31:0]   fpc;
  logic          push, pop, drop, fill;
  assign outstanding = {1'b0, pend} + {1'b0, disc};
  assign imem_req    = rst & ~StallF & (count < CW'(DEPTH)) & (outstanding < (CW+1)'(DEPTH));
  assign imem_addr   = fpc;
  assign push        = imem_req & imem_gnt;
  assign drop        = imem_rvalid & (disc != '0);
  assign fill        = imem_rvalid & (disc == '0) & ~PCSrcE;
  // pending entries are always the youngest ones, so the oldest pending sits pend slots behind tail
  assign fill_idx    = tail - pend[AW-1:0];
  assign ValidF      = count > pend;
  assign pop         = ValidF & ~StallD & ~PCSrcE;
  assign PCF         = ValidF ? pc_q[head] : '0;
  assign PCPlus4F    = ValidF ? pc_q[head] + 32'd4 : '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      pend   <= '0;
      disc   <= '0;
      fpc    <= RESET_PC;
      RDD    <= '0;
      ValidD <= 1'b0;
    end else begin
      if (PCSrcE) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
        pend  <= '0;
        // every in-flight request, including one granted now, must be swallowed later
        disc  <= disc + pend + CW'(push) - CW'(imem_rvalid);
        fpc   <= PCTargetE;
      end else begin
        head  <= head + AW'(pop);
        tail  <= tail + AW'(push);
        count <= count + CW'(push) - CW'(pop);
        pend  <= pend + CW'(push) - CW'(fill);
        disc  <= disc - CW'(drop);
        fpc   <= push ? fpc + 32'd4 : fpc;
      end
      ValidD <= FlushD ? 1'b0 : StallD ? ValidD : PCSrcE ? 1'b0 : ValidF;
      RDD    <= FlushD ? '0 : StallD ? RDD : (PCSrcE | ~ValidF) ? '0 : ins_q[head];
    end
  always_ff @(posedge clk) begin
    if (push & ~PCSrcE) pc_q[tail] <= fpc;
    if (fill) ins_q[fill_idx] <= imem_rdata;
  end
endmodule

// File: tb/tb_stage_f.sv
// tb_stage_f: randomized bench for stage_f; a variable-latency memory model plus a program-order
// reference (expected next PC, mem[a] = a ^ 32'hA5A5_0000) check every decode handoff.
`timescale 1ns/1ps
module tb_stage_f;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 4;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, PCSrcE = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] PCF, PCPlus4F, RDD;
  logic        ValidF, ValidD;

  stage_f #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .PCF(PCF), .PCPlus4F(PCPlus4F), .ValidF(ValidF), .RDD(RDD), .ValidD(ValidD)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] a; int due; } mreq_t;
  mreq_t       memq[$];
  int          cyc = 0, lat_lo = 1, lat_hi = 1, gnt_pct = 100;
  int          checks = 0, errors = 0;
  logic [31:0] exp_pc = RESET_PC, exp_rdd = '0;
  logic        exp_vd = 1'b0;
  logic        s_req, s_gnt, s_rv, s_vf, s_vd, s_pop;
  logic [31:0] s_addr, s_pcf, s_rdd;
  int          s_cyc;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // one clock cycle: sample mid-cycle, check against the reference, then advance memory and model
  task automatic tick();
    mreq_t m;
    @(negedge clk);
    s_req = imem_req; s_gnt = imem_gnt; s_addr = imem_addr; s_rv = imem_rvalid;
    s_vf = ValidF; s_pcf = PCF; s_vd = ValidD; s_rdd = RDD; s_cyc = cyc;
    s_pop = ValidF && !StallD && !PCSrcE;
    checks++;
    if (ValidD !== exp_vd || RDD !== exp_rdd) begin
      errors++;
      $display("FAIL decode_out cyc=%0d: ValidD=%b RDD=%h, expected ValidD=%b RDD=%h", cyc, ValidD, RDD, exp_vd, exp_rdd);
    end
    if (!ValidF) begin
      checks++;
      if (PCF !== 32'h0 || PCPlus4F !== 32'h0) begin
        errors++;
        $display("FAIL idle_pcf cyc=%0d: PCF=%h PCPlus4F=%h, expected 0", cyc, PCF, PCPlus4F);
      end
    end
    if (s_pop) begin
      checks++;
      if (PCF !== exp_pc || PCPlus4F !== exp_pc + 32'd4) begin
        errors++;
        $display("FAIL head_pc cyc=%0d: PCF=%h PCPlus4F=%h, expected %h %h", cyc, PCF, PCPlus4F, exp_pc, exp_pc + 32'd4);
      end
    end
    if (imem_req) begin
      checks++;
      if (memq.size() >= DEPTH) begin
        errors++;
        $display("FAIL outstanding cyc=%0d: req with %0d outstanding, limit %0d", cyc, memq.size(), DEPTH);
      end
    end
    if (FlushD || (!StallD && (PCSrcE || !ValidF))) begin
      exp_vd = 1'b0; exp_rdd = '0;
    end else if (!StallD) begin
      exp_vd = 1'b1; exp_rdd = memf(exp_pc);
    end
    if (s_pop) exp_pc += 32'd4;
    if (PCSrcE) exp_pc = PCTargetE;
    @(posedge clk);
    #1;
    if (s_rv) void'(memq.pop_front());
    if (s_req && s_gnt) begin
      m.a = s_addr;
      m.due = cyc + int'($urandom_range(lat_lo, lat_hi));
      memq.push_back(m);
    end
    cyc++;
    imem_rvalid = memq.size() > 0 && memq[0].due <= cyc;
    imem_rdata = imem_rvalid ? memf(memq[0].a) : $urandom;
    imem_gnt = int'($urandom_range(0, 99)) < gnt_pct;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    memq.delete();
    imem_rvalid = 1'b0; imem_gnt = 1'b0;
    StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    exp_pc = RESET_PC; exp_vd = 1'b0; exp_rdd = '0;
    imem_gnt = int'($urandom_range(0, 99)) < gnt_pct;
  endtask

  task automatic test_reset();
    gnt_pct = 100; lat_lo = 1; lat_hi = 1;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || ValidF !== 1'b0 || ValidD !== 1'b0 || RDD !== 32'h0 || PCF !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b ValidF=%b ValidD=%b RDD=%h PCF=%h, expected all 0", imem_req, ValidF, ValidD, RDD, PCF);
    end
    do_reset();
    tick();
    checks++;
    if (s_req !== 1'b1 || s_addr !== RESET_PC) begin
      errors++;
      $display("FAIL reset_first_addr: req=%b addr=%h, expected 1 %h", s_req, s_addr, RESET_PC);
    end
  endtask

  task automatic test_stream();
    int k = 0, first = -1, fvd = -1;
    lat_lo = 1; lat_hi = 1; gnt_pct = 100;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if (!(s_req && s_gnt) || s_addr !== RESET_PC + 32'(4 * k)) begin
        errors++;
        $display("FAIL stream_addr: req=%b gnt=%b addr=%h, expected granted %h", s_req, s_gnt, s_addr, RESET_PC + 32'(4 * k));
      end
      if (first < 0) first = s_cyc;
      k++;
      if (s_vd && fvd < 0) begin
        fvd = s_cyc;
        checks++;
        if (fvd != first + 3 || s_rdd !== 32'hA5A5_0000) begin
          errors++;
          $display("FAIL stream_latency: first ValidD at +%0d RDD=%h, expected +3 A5A50000", fvd - first, s_rdd);
        end
      end
    end
    checks++;
    if (fvd < 0) begin
      errors++;
      $display("FAIL stream_valid: ValidD never 1, expected 1 by cycle 3");
    end
  endtask

  task automatic test_stall_d();
    int pops = 0;
    StallD = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (s_req !== 1'b0) begin
      errors++;
      $display("FAIL stall_req: imem_req=%b with FIFO full, expected 0", s_req);
    end
    StallD = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      pops += int'(s_pop);
    end
    checks++;
    if (pops < 8) begin
      errors++;
      $display("FAIL stall_resume: %0d pops after release, expected >= 8", pops);
    end
  endtask

  task automatic test_flush();
    logic [31:0] h;
    StallD = 1'b1;
    tick();
    FlushD = 1'b1;
    tick();
    h = s_pcf;
    checks++;
    if (s_vf !== 1'b1) begin
      errors++;
      $display("FAIL flush_head_valid: ValidF=%b, expected 1", s_vf);
    end
    FlushD = 1'b0; StallD = 1'b0;
    tick();
    checks++;
    if (s_vd !== 1'b0 || s_rdd !== 32'h0) begin
      errors++;
      $display("FAIL flush_clear: ValidD=%b RDD=%h, expected 0 0", s_vd, s_rdd);
    end
    checks++;
    if (!s_pop || s_pcf !== h) begin
      errors++;
      $display("FAIL flush_keep_head: pop=%b PCF=%h, expected 1 %h", s_pop, s_pcf, h);
    end
    tick();
    checks++;
    if (s_vd !== 1'b1 || s_rdd !== memf(h)) begin
      errors++;
      $display("FAIL flush_deliver: ValidD=%b RDD=%h, expected 1 %h", s_vd, s_rdd, memf(h));
    end
  endtask

  task automatic test_redirect();
    bit got_addr = 0, got_vf = 0, got_vd = 0;
    int nrv = 0;
    lat_lo = 3; lat_hi = 3; gnt_pct = 100;
    do_reset();
    tick();
    tick();
    PCSrcE = 1'b1; PCTargetE = 32'h100;
    tick();
    checks++;
    if (!(s_req && s_gnt)) begin
      errors++;
      $display("FAIL redirect_gnt: req=%b gnt=%b in redirect cycle, expected 1 1", s_req, s_gnt);
    end
    PCSrcE = 1'b0;
    for (int i = 0; i < 30 && !got_vd; i++) begin
      tick();
      if (!got_addr && s_req && s_gnt) begin
        got_addr = 1;
        checks++;
        if (s_addr !== 32'h100) begin
          errors++;
          $display("FAIL redirect_addr: first granted addr %h, expected 00000100", s_addr);
        end
      end
      if (!got_vf) begin
        if (s_vf) begin
          got_vf = 1;
          checks++;
          if (nrv != 4 || s_pcf !== 32'h100) begin
            errors++;
            $display("FAIL redirect_drop: %0d responses before head, PCF=%h, expected 4 00000100", nrv, s_pcf);
          end
        end else nrv += int'(s_rv);
      end
      if (s_vd) begin
        got_vd = 1;
        checks++;
        if (s_rdd !== memf(32'h100)) begin
          errors++;
          $display("FAIL redirect_rdd: RDD=%h, expected %h", s_rdd, memf(32'h100));
        end
      end
    end
    checks++;
    if (!got_vd) begin
      errors++;
      $display("FAIL redirect_timeout: no ValidD within 30 cycles, expected one");
    end
  endtask

  task automatic test_random();
    int delivered = 0, n = 0;
    lat_lo = 1; lat_hi = 5; gnt_pct = 60;
    do_reset();
    while (delivered < 200 && n < 6000) begin
      StallF = $urandom_range(0, 9) == 0;
      StallD = $urandom_range(0, 6) == 0;
      FlushD = $urandom_range(0, 19) == 0;
      PCSrcE = (n % 37) == 36;
      PCTargetE = $urandom & 32'hFFFF_FFFC;
      tick();
      n++;
      if (s_pop && !FlushD) delivered++;
    end
    StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
    checks++;
    if (delivered < 200) begin
      errors++;
      $display("FAIL random_progress: %0d delivered in %0d cycles, expected 200", delivered, n);
    end
  endtask

  task automatic test_reset_mid();
    lat_lo = 3; lat_hi = 3; gnt_pct = 100;
    do_reset();
    for (int i = 0; i < 20 && !(memq.size() >= 3 && s_vd); i++) tick();
    #3 rst = 1'b0;
    #1;
    checks++;
    if (ValidF !== 1'b0 || ValidD !== 1'b0 || RDD !== 32'h0 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: ValidF=%b ValidD=%b RDD=%h req=%b, expected all 0", ValidF, ValidD, RDD, imem_req);
    end
    do_reset();
    tick();
    checks++;
    if (s_req !== 1'b1 || s_addr !== RESET_PC) begin
      errors++;
      $display("FAIL reset_mid_addr: req=%b addr=%h, expected 1 %h", s_req, s_addr, RESET_PC);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_d();
    test_flush();
    test_redirect();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
